// File: rtl/alu_exec_unit.sv
// alu_exec_unit
//   Execute-stage ALU. It takes the 4-bit ALUControl code from the ALU
//   control decoder. Single-cycle ops register their result one clock after
//   Start. mul (code 8) runs as an iterative shift-add multiplier that
//   retires MUL_STEP_BITS multiplier bits per clock. It also produces the
//   Zero/branch-condition flag.
// Ports
//   Clk        : clock, rising edge
//   Reset      : synchronous, active-high
//   Start      : op request, sampled only while Busy=0
//   ALUControl : op code (0-9 arithmetic/logic/mul, 10-14 branch, 15 undefined)
//   A, B       : operands (A[4:0] is the shift amount for sll/srl, B is the value shifted)
//   Busy       : high while a multiply iterates
//   Done       : one-cycle pulse, ALUResult/Zero valid
//   ALUResult  : registered result, held until the next completion
//   Zero       : registered zero/branch-condition flag
module alu_exec_unit #(
  parameter int unsigned WIDTH         = 32,
  parameter int unsigned MUL_STEP_BITS = 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [3:0]       ALUControl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero
);

  localparam int unsigned N  = WIDTH / MUL_STEP_BITS;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, MUL} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] mcand, mplier, acc;
  logic [WIDTH-1:0] partial, mul_sum;
  logic [WIDTH-1:0] alu_res;
  logic             alu_zero;
  logic [CW-1:0]    count;
  logic             accept, accept_mul, last_step;

  assign accept     = (state == IDLE) && Start;
  assign accept_mul = accept && (ALUControl == 4'd8);
  assign last_step  = (state == MUL) && (count == CW'(N - 1));

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept_mul) state_next = MUL;
      MUL:     if (last_step)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    Busy = (state == MUL);
  end

  // Single-cycle result and flag
  always_comb begin
    alu_res  = '0;
    alu_zero = 1'b0;
    case (ALUControl)
      4'd0:  alu_res = A + B;
      4'd1:  alu_res = A - B;
      4'd2:  alu_res = A & B;
      4'd3:  alu_res = A | B;
      4'd4:  alu_res = ~(A | B);
      4'd5:  alu_res = A ^ B;
      4'd6:  alu_res = B << A[4:0];
      4'd7:  alu_res = B >> A[4:0];
      4'd9:  alu_res = WIDTH'($signed(A) < $signed(B));
      4'd10: alu_zero = !A[WIDTH-1];
      4'd11: alu_zero = (A != B);
      4'd12: alu_zero = !A[WIDTH-1] && (A != '0);
      4'd13: alu_zero = A[WIDTH-1] || (A == '0);
      4'd14: alu_zero = A[WIDTH-1];
      4'd15: alu_zero = 1'b1;
      default: alu_res = '0;
    endcase
    if (ALUControl <= 4'd9) alu_zero = (alu_res == '0);
  end

  // Partial product for the multiplier bits retired this step; walks shifted
  // copies so no variable bit index is needed.
  always_comb begin
    logic [WIDTH-1:0] mc_s;
    logic [WIDTH-1:0] mp_s;
    partial = '0;
    mc_s    = mcand;
    mp_s    = mplier;
    for (int unsigned i = 0; i < MUL_STEP_BITS; i++) begin
      if (mp_s[0]) partial = partial + mc_s;
      mc_s = mc_s << 1;
      mp_s = mp_s >> 1;
    end
  end

  assign mul_sum = acc + partial;

  // Datapath and result registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Done      <= 1'b0;
      ALUResult <= '0;
      Zero      <= 1'b0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      count     <= '0;
    end else begin
      Done <= 1'b0;
      if (accept_mul) begin
        mcand  <= A;
        mplier <= B;
        acc    <= '0;
        count  <= '0;
      end else if (accept) begin
        ALUResult <= alu_res;
        Zero      <= alu_zero;
        Done      <= 1'b1;
      end else if (state == MUL) begin
        mcand  <= mcand << MUL_STEP_BITS;
        mplier <= mplier >> MUL_STEP_BITS;
        acc    <= mul_sum;
        count  <= count + 1'b1;
        if (last_step) begin
          ALUResult <= mul_sum;
          Zero      <= (mul_sum == '0);
          Done      <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit
//   Self-checking bench for alu_exec_unit (WIDTH=32, MUL_STEP_BITS=1):
//   directed cases followed by randomized ops checked against a plain
//   arithmetic reference model.
module tb_alu_exec_unit;

  localparam int unsigned W = 32;

  logic         Clk;
  logic         Reset;
  logic         Start;
  logic [3:0]   ALUControl;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Busy;
  logic         Done;
  logic [W-1:0] ALUResult;
  logic         Zero;

  int errors = 0;
  int checks = 0;

  alu_exec_unit #(.WIDTH(W), .MUL_STEP_BITS(1)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start      (Start),
    .ALUControl (ALUControl),
    .A          (A),
    .B          (B),
    .Busy       (Busy),
    .Done       (Done),
    .ALUResult  (ALUResult),
    .Zero       (Zero)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: op semantics straight from the op-code table.
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic z);
    int          sa;
    int          sb;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    r  = 32'd0;
    z  = 1'b0;
    case (op)
      4'd0:  r = a + b;
      4'd1:  r = a - b;
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = ~(a | b);
      4'd5:  r = a ^ b;
      4'd6:  r = b << a[4:0];
      4'd7:  r = b >> a[4:0];
      4'd8:  begin p = {32'd0, a} * {32'd0, b}; r = p[31:0]; end
      4'd9:  r = (sa < sb) ? 32'd1 : 32'd0;
      4'd10: z = (sa >= 0);
      4'd11: z = (a != b);
      4'd12: z = (sa > 0);
      4'd13: z = (sa <= 0);
      4'd14: z = (sa < 0);
      default: z = 1'b1;
    endcase
    if (op <= 4'd9) z = (r == 32'd0);
  endfunction

  // Issue one op and wait for its Done; while a multiply runs, inputs are
  // scrambled and Start is randomly pulsed, all of which must be ignored.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit hold_check);
    logic [31:0] er;
    logic        ez;
    int          cycles;
    int          lat;
    model(op, a, b, er, ez);
    lat = (op == 4'd8) ? W + 1 : 1;
    @(negedge Clk);
    Start = 1'b1; ALUControl = op; A = a; B = b;
    @(posedge Clk); #1;
    Start  = 1'b0;
    cycles = 1;
    while (!Done && cycles < 40) begin
      check("busy_during_op", Busy, 1);
      Start      = 1'($urandom);
      ALUControl = 4'($urandom);
      A          = $urandom;
      B          = $urandom;
      @(posedge Clk); #1;
      Start  = 1'b0;
      cycles++;
    end
    check("latency", cycles, lat);
    check("done", Done, 1);
    check("busy_end", Busy, 0);
    check("result", ALUResult, er);
    check("zero", Zero, ez);
    if (hold_check) begin
      @(posedge Clk); #1;
      check("done_drop", Done, 0);
      check("result_hold", ALUResult, er);
      check("zero_hold", Zero, ez);
    end
  endtask

  initial begin
    int done_cnt;
    Reset = 1'b1; Start = 1'b0; ALUControl = 4'd0; A = '0; B = '0;
    repeat (2) @(posedge Clk);
    #1;
    check("reset_busy", Busy, 0);
    check("reset_done", Done, 0);
    check("reset_result", ALUResult, 0);
    check("reset_zero", Zero, 0);
    Reset = 1'b0;

    // Directed cases
    run_op(4'd0, 32'd5, 32'd7, 1'b1);
    run_op(4'd1, 32'h1234, 32'h1234, 1'b1);
    run_op(4'd8, 32'hFFFF_FFFD, 32'd7, 1'b1);
    run_op(4'd14, 32'h8000_0000, 32'd0, 1'b0);
    run_op(4'd12, 32'd0, 32'd5, 1'b0);
    run_op(4'd6, 32'd4, 32'd1, 1'b0);
    run_op(4'd7, 32'd31, 32'h8000_0000, 1'b0);
    run_op(4'd9, 32'hFFFF_FFFF, 32'd1, 1'b0);
    run_op(4'd15, 32'd3, 32'd3, 1'b1);
    run_op(4'd8, 32'd0, 32'h1234_5678, 1'b1);

    // Start with code 0 at cycle 10 of a multiply: exactly one Done, mul result
    @(negedge Clk);
    Start = 1'b1; ALUControl = 4'd8; A = 32'd123456; B = 32'd789;
    @(posedge Clk); #1;
    Start = 1'b0;
    done_cnt = 0;
    for (int i = 1; i < 45; i++) begin
      if (i == 10) begin
        Start = 1'b1; ALUControl = 4'd0; A = 32'd1; B = 32'd2;
      end
      @(posedge Clk); #1;
      Start = 1'b0;
      if (Done) begin
        done_cnt++;
        check("mul_ignore_result", ALUResult, 32'd97406784);
      end
    end
    check("mul_ignore_done_count", done_cnt, 1);

    // Reset in the middle of a multiply
    @(negedge Clk);
    Start = 1'b1; ALUControl = 4'd8; A = 32'd9; B = 32'd9;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (4) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk); #1;
    check("abort_busy", Busy, 0);
    check("abort_done", Done, 0);
    check("abort_result", ALUResult, 0);
    Reset = 1'b0;
    repeat (40) begin
      @(posedge Clk); #1;
      check("abort_no_done", Done, 0);
    end
    run_op(4'd0, 32'd5, 32'd7, 1'b1);

    // Reset together with Start: reset wins
    @(negedge Clk);
    Reset = 1'b1; Start = 1'b1; ALUControl = 4'd0; A = 32'd5; B = 32'd7;
    @(posedge Clk); #1;
    check("rst_start_done", Done, 0);
    check("rst_start_result", ALUResult, 0);
    check("rst_start_busy", Busy, 0);
    Reset = 1'b0; Start = 1'b0;
    @(posedge Clk); #1;
    check("rst_start_after", Done, 0);

    // Randomized ops, mixed back-to-back and spaced issue
    for (int n = 0; n < 200; n++) begin
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0: b = a;
        1: a = 32'd0;
        2: a = 32'($urandom_range(0, 40));
        default: ;
      endcase
      run_op(op, a, b, 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
